uart_cmd_sequencer: RTL and testbench

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

---
 rtl/uart_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// Command sequencer: buffers 32-bit command words in a circular FIFO and
// forwards them downstream, interpreting delay and set-gap commands locally.
module uart_cmd_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned MS_CNT       = 50000,
  parameter logic [15:0] DELAY_HEADER = 16'hABCD,
  parameter logic [15:0] WAIT_HEADER  = 16'hABC1,
  parameter logic [15:0] GAP_RST      = 16'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     abort,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CYC_W = (MS_CNT > 1) ? $clog2(MS_CNT) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MS_CNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_GAP,
    ST_DELAY,
    ST_SEND
  } state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      gap_ms;
  logic [15:0]      delay_ms;
  logic [CYC_W-1:0] cyc_cnt;
  logic [15:0]      ms_cnt;

  logic             full;
  logic             push;
  logic             pop;
  logic [31:0]      head;
  logic [15:0]      head_hdr;
  logic [15:0]      head_arg;
  logic             ms_wrap;
  logic             gap_done;
  logic             delay_done;

  assign full       = (count == CNT_W'(DEPTH));
  assign in_ready   = !full;
  assign fifo_count = count;
  assign busy       = (state != ST_IDLE);

  assign head     = mem[rd_ptr];
  assign head_hdr = head[31:16];
  assign head_arg = head[15:0];

  // Words are dropped while full or while the FIFO is being flushed
  assign push = in_valid && !full && !abort;
  assign pop  = ((state == ST_DECODE) &&
                 ((head_hdr == DELAY_HEADER) || (head_hdr == WAIT_HEADER))) ||
                ((state == ST_SEND) && out_ready);

  assign ms_wrap    = (cyc_cnt == CYC_LAST);
  assign gap_done   = ms_wrap && (ms_cnt == (gap_ms - 16'd1));
  assign delay_done = ms_wrap && (ms_cnt == (delay_ms - 16'd1));

  // FIFO storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Sticky overflow; a new overflow event wins over a clear
  always_ff @(posedge clk) begin
    if (rst)                    overflow <= 1'b0;
    else if (in_valid && full)  overflow <= 1'b1;
    else if (ovf_clr)           overflow <= 1'b0;
  end

  // Sequencer FSM with millisecond timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      gap_ms    <= GAP_RST;
      delay_ms  <= '0;
      cyc_cnt   <= '0;
      ms_cnt    <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      cyc_cnt   <= '0;
      ms_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (head_hdr == DELAY_HEADER) begin
            delay_ms <= head_arg;
            state    <= (head_arg == 16'd0) ? ST_IDLE : ST_DELAY;
          end else if (head_hdr == WAIT_HEADER) begin
            gap_ms <= head_arg;
            state  <= ST_IDLE;
          end else begin
            out_data <= head;
            if (gap_ms != 16'd0) begin
              state <= ST_GAP;
            end else begin
              state     <= ST_SEND;
              out_valid <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state     <= ST_SEND;
            out_valid <= 1'b1;
            cyc_cnt   <= '0;
            ms_cnt    <= '0;
          end else if (ms_wrap) begin
            cyc_cnt <= '0;
            ms_cnt  <= ms_cnt + 16'd1;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        ST_DELAY: begin
          if (delay_done) begin
            state   <= ST_IDLE;
            cyc_cnt <= '0;
            ms_cnt  <= '0;
          end else if (ms_wrap) begin
            cyc_cnt <= '0;
            ms_cnt  <= ms_cnt + 16'd1;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed self-checking bench for uart_cmd_sequencer (DEPTH=8, MS_CNT=10).
module tb_uart_cmd_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned MS    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        abort;
  logic        ovf_clr;
  logic [3:0]  fifo_count;
  logic        busy;
  logic        overflow;

  int n_vec   = 0;
  int n_err   = 0;
  int bad_fwd = 0;

  uart_cmd_sequencer #(.DEPTH(DEPTH), .MS_CNT(MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .abort      (abort),
    .ovf_clr    (ovf_clr),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample just after it; note any forwarded control word
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid && ((out_data[31:16] == 16'hABCD) || (out_data[31:16] == 16'hABC1)))
      bad_fwd++;
  endtask

  task automatic put_word(input logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_t, output int n);
    n = 0;
    while (!out_valid && n < max_t) begin
      tick();
      n++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    abort = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_count",     32'(fifo_count), 32'd0);
    chk("rst_overflow",  32'(overflow), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);

    // Gap 0, then exact two-edge latency and one-cycle valid
    put_word(32'hABC1_0000);
    repeat (4) tick();
    chk("wait_cmd_count", 32'(fifo_count), 32'd0);
    chk("wait_cmd_busy",  32'(busy), 32'd0);
    put_word(32'h1234_5678);
    chk("lat_k_valid", 32'(out_valid), 32'd0);
    chk("lat_k_count", 32'(fifo_count), 32'd1);
    tick();
    chk("lat_k1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_k2_valid", 32'(out_valid), 32'd1);
    chk("lat_k2_data",  out_data, 32'h1234_5678);
    tick();
    chk("lat_k3_valid", 32'(out_valid), 32'd0);
    chk("lat_k3_count", 32'(fifo_count), 32'd0);

    // 1 ms gap with two words back to back
    put_word(32'hABC1_0001);
    repeat (4) tick();
    put_word(32'h0000_00AA);
    put_word(32'h0000_00BB);
    wait_valid(50, n);
    chk("gap_a_lat",  32'(n), 32'd11);
    chk("gap_a_data", out_data, 32'h0000_00AA);
    tick();
    wait_valid(50, n);
    chk("gap_b_lat",  32'(n), 32'd12);
    chk("gap_b_data", out_data, 32'h0000_00BB);
    tick();
    chk("gap_done_valid", 32'(out_valid), 32'd0);
    chk("gap_done_count", 32'(fifo_count), 32'd0);

    // 3 ms delay, then 1 ms gap, then forward
    put_word(32'hABCD_0003);
    put_word(32'h0000_0001);
    wait_valid(100, n);
    chk("delay_lat",  32'(n), 32'd43);
    chk("delay_data", out_data, 32'h0000_0001);
    tick();

    // Zero-length delay returns straight to idle; gap back to 0
    put_word(32'hABCD_0000);
    put_word(32'hABC1_0000);
    repeat (6) tick();
    chk("zero_delay_busy",  32'(busy), 32'd0);
    chk("zero_delay_count", 32'(fifo_count), 32'd0);

    // Overflow with downstream stalled, then ordered drain across wrap
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_data  = 32'h1000_0000 + 32'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("ovf_count",    32'(fifo_count), 32'(DEPTH));
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    chk("ovf_flag",     32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(overflow), 32'd0);
    in_data  = 32'hDEAD_0000;
    in_valid = 1'b1;
    tick();
    chk("ovf_clr_vs_set", 32'(overflow), 32'd1);
    in_valid = 1'b0;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 32'd0);
    chk("full_in_ready_pop", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wait_valid(20, n);
      chk("drain_data", out_data, 32'h1000_0000 + 32'(i));
      tick();
    end
    chk("drain_count", 32'(fifo_count), 32'd0);

    // Abort during SEND with five words queued; gap must survive
    put_word(32'hABC1_0002);
    repeat (4) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) put_word(32'h2000_0000 + 32'(i));
    wait_valid(100, n);
    chk("abort_pre_count", 32'(fifo_count), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_busy",  32'(busy), 32'd0);
    out_ready = 1'b1;
    put_word(32'h3000_0001);
    wait_valid(100, n);
    chk("abort_gap_lat",  32'(n), 32'd22);
    chk("abort_gap_data", out_data, 32'h3000_0001);
    tick();

    // Reset mid-delay abandons everything, gap back to default
    put_word(32'hABCD_0005);
    put_word(32'h5555_AAAA);
    repeat (10) tick();
    chk("mid_delay_busy",  32'(busy), 32'd1);
    chk("mid_delay_count", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_data",  out_data, 32'd0);
    chk("rst2_count",     32'(fifo_count), 32'd0);
    chk("rst2_busy",      32'(busy), 32'd0);
    chk("rst2_overflow",  32'(overflow), 32'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst2_no_valid", 32'(seen), 32'd0);
    put_word(32'h7777_0001);
    wait_valid(100, n);
    chk("rst2_gap_lat",  32'(n), 32'd12);
    chk("rst2_gap_data", out_data, 32'h7777_0001);
    tick();

    chk("ctrl_word_forwarded", 32'(bad_fwd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
